// File: rtl/uart_line_tx.sv
`default_nettype none
// ============================================================================
// Module : uart_line_tx
// Serialises a NUM_BYTES-character ASCII line as back-to-back 8N1 UART frames.
// Rev    : 1.0 - initial release
// ============================================================================
module uart_line_tx #(
  parameter int NUM_BYTES = 14,
  parameter int BAUD_DIV  = 10417
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] line_in,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam int LW = 8 * NUM_BYTES;
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [CW-1:0] c_BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] c_BYTE_LAST = BW'(NUM_BYTES - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [BW-1:0] byte_idx_q, byte_idx_d;
  logic [LW-1:0] line_q, line_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          w_tick;
  logic [7:0]    w_cur_byte;

  assign w_tick     = (baud_cnt_q == c_BAUD_LAST);
  // The line register shifts left once per byte, so the byte on the wire is always the top one.
  assign w_cur_byte = line_d[LW-1 -: 8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= c_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      line_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      line_q     <= line_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    line_d     = line_q;
    if (state_q == c_IDLE) begin
      baud_cnt_d = '0;
      if (start) begin
        line_d     = line_in;
        bit_idx_d  = '0;
        byte_idx_d = '0;
        state_d    = c_START;
      end
    end else begin
      baud_cnt_d = w_tick ? '0 : baud_cnt_q + CW'(1);
      if (w_tick) begin
        case (state_q)
          c_START: begin
            bit_idx_d = '0;
            state_d   = c_DATA;
          end
          c_DATA: begin
            if (bit_idx_q == 3'd7) state_d = c_STOP;
            else                   bit_idx_d = bit_idx_q + 3'd1;
          end
          c_STOP: begin
            if (byte_idx_q == c_BYTE_LAST) begin
              state_d = c_IDLE;
            end else begin
              byte_idx_d = byte_idx_q + BW'(1);
              line_d     = line_q << 8;
              state_d    = c_START;
            end
          end
          default: state_d = c_IDLE;
        endcase
      end
    end
  end

  // Outputs are registered from the next state so tx/busy change on the same edge as the state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != c_IDLE);
    done_d = (state_q == c_STOP) && (state_d == c_IDLE);
    case (state_d)
      c_START: tx_d = 1'b0;
      c_DATA:  tx_d = w_cur_byte[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire
